// File: rtl/pc_pkg.sv
// Shared types and default parameters for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HALT
  } pc_state_e;

  localparam int unsigned     XLEN_DEFAULT      = 32;
  localparam logic [31:0]     RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0]     TRAP_VEC_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap, redirect (with alignment check), hold, increment.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEFAULT),
  parameter int unsigned     INC      = 4,
  parameter int unsigned     ALIGN    = 4
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_en,
  input  logic            trap_valid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  input  logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_inc,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  // ALIGN is a power of two, so the low bits below it must all be zero.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN - 1);

  logic target_misaligned;

  assign pc_inc            = pc + XLEN'(INC);
  assign target_misaligned = |(redirect_pc & ALIGN_MASK);

  always_comb begin
    next_pc  = pc;
    misalign = 1'b0;
    if (trap_valid) begin
      next_pc = TRAP_VEC;
    end else if (redirect_en && redirect_valid) begin
      if (target_misaligned) begin
        next_pc  = TRAP_VEC;
        misalign = 1'b1;
      end else begin
        next_pc = redirect_pc;
      end
    end else if (stall || (fetch_valid && !fetch_ready)) begin
      next_pc = pc;
    end else if (fetch_valid && fetch_ready) begin
      next_pc = pc_inc;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: PC register, BOOT/RUN/HALT control FSM and misalign flag.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEFAULT),
  parameter int unsigned     INC       = 4,
  parameter int unsigned     ALIGN     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            misalign_err,
  output logic            halted
);

  pc_state_e       state;
  pc_state_e       state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            redirect_en;

  pc_next_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC),
    .INC      (INC),
    .ALIGN    (ALIGN)
  ) u_next_sel (
    .pc             (pc),
    .redirect_en    (redirect_en),
    .trap_valid     (trap_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .pc_inc         (pc_plus_inc),
    .next_pc        (next_pc),
    .misalign       (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PC_BOOT;
      pc           <= RESET_VEC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= next_pc;
      misalign_err <= misalign;
    end
  end

  // HALT is only entered at a fetch boundary, i.e. when the current request is accepted.
  always_comb begin
    state_next  = state;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    redirect_en = 1'b1;
    case (state)
      PC_BOOT: begin
        state_next = PC_RUN;
      end
      PC_RUN: begin
        fetch_valid = 1'b1;
        if (halt_req && fetch_ready) begin
          state_next = PC_HALT;
        end
      end
      PC_HALT: begin
        halted      = 1'b1;
        redirect_en = 1'b0;
        if (trap_valid || resume) begin
          state_next = PC_RUN;
        end
      end
      default: begin
        state_next = PC_BOOT;
      end
    endcase
  end

  assign fetch_pc = pc;

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen: each vector drives one cycle and checks the post-edge outputs.
module tb_pc_gen;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        trap;
    logic        hreq;
    logic        resume;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        exp_halted;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        halt_req;
  logic        resume;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] pc_plus_inc;
  logic        misalign_err;
  logic        halted;

  int vectors_applied = 0;
  int miscompares     = 0;

  vec_t vecs[$];

  pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .halt_req       (halt_req),
    .resume         (resume),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .pc_plus_inc    (pc_plus_inc),
    .misalign_err   (misalign_err),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string name, logic r, logic st, logic rv, logic [31:0] rpc,
                              logic tr, logic hq, logic rs, logic rdy,
                              logic ev, logic [31:0] epc, logic em, logic eh);
    vec_t v;
    v.name = name;  v.rst = r;   v.stall = st;  v.rv = rv;  v.rpc = rpc;
    v.trap = tr;    v.hreq = hq; v.resume = rs; v.ready = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_mis = em; v.exp_halted = eh;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic ev, input logic [31:0] epc,
                             input logic em, input logic eh);
    logic [66:0] got;
    logic [66:0] exp;
    got = {fetch_valid, fetch_pc, pc_plus_inc, misalign_err, halted};
    exp = {ev, epc, epc + 32'd4, em, eh};
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got valid=%b pc=%h pc_inc=%h mis=%b halted=%b, want valid=%b pc=%h pc_inc=%h mis=%b halted=%b",
               name, fetch_valid, fetch_pc, pc_plus_inc, misalign_err, halted,
               ev, epc, epc + 32'd4, em, eh);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    stall          = v.stall;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    trap_valid     = v.trap;
    halt_req       = v.hreq;
    resume         = v.resume;
    fetch_ready    = v.ready;
    @(posedge clk);
    #1;
    checkOutput(v.name, v.exp_valid, v.exp_pc, v.exp_mis, v.exp_halted);
  endtask

  initial begin
    int boot_wait;
    logic [31:0] model_pc;

    //                name            rst st rv rpc            tr hq rs rdy  valid pc            mis halt
    vecs.push_back(mk("reset",         1, 0, 0, 32'h0,         0, 0, 0, 0,   0, 32'h0,         0, 0));
    vecs.push_back(mk("boot_exit",     0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h0,         0, 0));
    vecs.push_back(mk("seq_4",         0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h4,         0, 0));
    vecs.push_back(mk("seq_8",         0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h8,         0, 0));
    vecs.push_back(mk("seq_c",         0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'hC,         0, 0));
    vecs.push_back(mk("seq_10",        0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h10,        0, 0));
    vecs.push_back(mk("wait_1",        0, 0, 0, 32'h0,         0, 0, 0, 0,   1, 32'h10,        0, 0));
    vecs.push_back(mk("wait_2",        0, 0, 0, 32'h0,         0, 0, 0, 0,   1, 32'h10,        0, 0));
    vecs.push_back(mk("wait_3",        0, 0, 0, 32'h0,         0, 0, 0, 0,   1, 32'h10,        0, 0));
    vecs.push_back(mk("accept_14",     0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h14,        0, 0));
    vecs.push_back(mk("trap_beats_rd", 0, 0, 1, 32'h200,       1, 0, 0, 1,   1, 32'h100,       0, 0));
    vecs.push_back(mk("rd_pending",    0, 0, 1, 32'h200,       0, 0, 0, 0,   1, 32'h200,       0, 0));
    vecs.push_back(mk("rd_misalign",   0, 0, 1, 32'h202,       0, 0, 0, 0,   1, 32'h100,       1, 0));
    vecs.push_back(mk("mis_pulse_end", 0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h104,       0, 0));
    vecs.push_back(mk("stall_hold",    0, 1, 0, 32'h0,         0, 0, 0, 1,   1, 32'h104,       0, 0));
    vecs.push_back(mk("after_stall",   0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h108,       0, 0));
    vecs.push_back(mk("rd_to_40",      0, 0, 1, 32'h40,        0, 0, 0, 1,   1, 32'h40,        0, 0));
    vecs.push_back(mk("halt_enter",    0, 0, 0, 32'h0,         0, 1, 0, 1,   0, 32'h44,        0, 1));
    vecs.push_back(mk("halt_ign_rd",   0, 1, 1, 32'h82,        0, 0, 0, 1,   0, 32'h44,        0, 1));
    vecs.push_back(mk("halt_stay",     0, 0, 0, 32'h0,         0, 0, 0, 1,   0, 32'h44,        0, 1));
    vecs.push_back(mk("resume",        0, 0, 0, 32'h0,         0, 0, 1, 1,   1, 32'h44,        0, 0));
    vecs.push_back(mk("resume_wait",   0, 0, 0, 32'h0,         0, 0, 0, 0,   1, 32'h44,        0, 0));
    vecs.push_back(mk("halt_pending",  0, 0, 0, 32'h0,         0, 1, 0, 0,   1, 32'h44,        0, 0));
    vecs.push_back(mk("halt_accept",   0, 0, 0, 32'h0,         0, 1, 0, 1,   0, 32'h48,        0, 1));
    vecs.push_back(mk("trap_wake",     0, 0, 0, 32'h0,         1, 0, 0, 0,   1, 32'h100,       0, 0));
    vecs.push_back(mk("rd_top",        0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1,   1, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk("wrap_0",        0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h0,         0, 0));
    vecs.push_back(mk("seq_4b",        0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h4,         0, 0));
    vecs.push_back(mk("pend_4",        0, 0, 0, 32'h0,         0, 0, 0, 0,   1, 32'h4,         0, 0));
    vecs.push_back(mk("rst_mid_hs",    1, 0, 1, 32'h300,       1, 0, 0, 0,   0, 32'h0,         0, 0));
    vecs.push_back(mk("boot_exit_b",   0, 0, 0, 32'h0,         0, 0, 0, 1,   1, 32'h0,         0, 0));
    vecs.push_back(mk("reset_c",       1, 0, 0, 32'h0,         0, 0, 0, 1,   0, 32'h0,         0, 0));
    vecs.push_back(mk("trap_in_boot",  0, 0, 0, 32'h0,         1, 0, 0, 1,   1, 32'h100,       0, 0));
    vecs.push_back(mk("rd_and_halt",   0, 0, 1, 32'h500,       0, 1, 0, 1,   0, 32'h500,       0, 1));
    vecs.push_back(mk("trap_resume",   0, 0, 0, 32'h0,         1, 0, 1, 1,   1, 32'h100,       0, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Hand sequence: reset, then the first request must appear after exactly one idle BOOT cycle.
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0; fetch_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    boot_wait = 0;
    while (!fetch_valid && boot_wait < 8) begin
      @(posedge clk); #1;
      boot_wait++;
    end
    vectors_applied++;
    if (boot_wait != 1) begin
      miscompares++;
      $display("[TB] FAIL boot_latency: got %0d cycles, want 1", boot_wait);
    end

    // Hand sequence: randomly gated ready, tracked by a simple accept-and-increment model.
    model_pc = 32'h0;
    for (int k = 0; k < 20; k++) begin
      fetch_ready = 1'($urandom_range(0, 1));
      if (fetch_ready) model_pc = model_pc + 32'd4;
      @(posedge clk); #1;
      checkOutput("rand_ready", 1'b1, model_pc, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
